// File: rtl/mux4_lane_scheduler_pkg.sv
// Shared definitions for the 4-lane round-robin burst scheduler.
//   state_t : FSM encoding (IDLE / BURST)
//   lane_t  : lane index type (LANE_W bits)
//   NLANES  : number of lane sources
package mux4_lane_scheduler_pkg;

    localparam int LANE_W = 2;
    localparam int NLANES = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef logic [LANE_W-1:0] lane_t;

endpackage

// File: rtl/mux4_lane_scheduler_rr_pick4.sv
// Combinational round-robin picker for four requesters.
// The search starts at the lane after `last` and wraps, so the lane at `last`
// is considered only when nobody else is requesting.
//   req   in  4  request vector, bit i = lane i wants service
//   last  in  2  most recently granted lane
//   hit   out 1  at least one request found
//   grant out 2  chosen lane (equals last when hit=0)
module rr_pick4
    import mux4_lane_scheduler_pkg::*;
(
    input  logic [NLANES-1:0] req,
    input  lane_t             last,
    output logic              hit,
    output lane_t             grant
);

    lane_t cand;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        hit   = 1'b0;
        grant = last;
        cand  = last;
        for (int k = 1; k <= NLANES; k++) begin
            // 2-bit addition wraps naturally modulo 4; k=4 lands back on last.
            cand = last + lane_t'(k);
            if (!hit && req[cand]) begin
                hit   = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_lane_scheduler.sv
// Round-robin burst scheduler feeding one registered byte stream from four
// lane sources. A granted lane may deliver up to MAX_BURST bytes before the
// grant rotates; a drained lane gives up its grant immediately.
//   clk_4f                 in   clock, all state on rising edge
//   reset                  in   synchronous, active-high
//   valid0..3              in   lane i has a byte available
//   data_in0..3_mux        in   lane i byte
//   pop0..3                out  lane i byte consumed this cycle (combinational)
//   out_ready              in   downstream accepts dataout_mux this cycle
//   validout               out  dataout_mux holds a valid byte
//   dataout_mux            out  registered output byte
//   sel                    out  currently granted lane (registered)
//   busy                   out  FSM is in BURST
module mux4_lane_scheduler
    import mux4_lane_scheduler_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              valid0,
    input  logic              valid1,
    input  logic              valid2,
    input  logic              valid3,
    input  logic [DATA_W-1:0] data_in0_mux,
    input  logic [DATA_W-1:0] data_in1_mux,
    input  logic [DATA_W-1:0] data_in2_mux,
    input  logic [DATA_W-1:0] data_in3_mux,
    output logic              pop0,
    output logic              pop1,
    output logic              pop2,
    output logic              pop3,
    input  logic              out_ready,
    output logic              validout,
    output logic [DATA_W-1:0] dataout_mux,
    output logic [1:0]        sel,
    output logic              busy
);

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t            state;
    lane_t             last;
    logic [3:0]        burst_cnt;
    logic [NLANES-1:0] req;
    logic              slot_free;
    logic              acc;
    logic              pick_hit;
    lane_t             pick;
    logic [DATA_W-1:0] sel_data;

    assign req = {valid3, valid2, valid1, valid0};

    // The single output register can take a byte if empty or being drained.
    assign slot_free = !validout || out_ready;

    // Reset gates acc so nothing is popped while reset is asserted.
    assign acc = !reset && (state == BURST) && req[sel] && slot_free;

    assign pop0 = acc && (sel == 2'd0);
    assign pop1 = acc && (sel == 2'd1);
    assign pop2 = acc && (sel == 2'd2);
    assign pop3 = acc && (sel == 2'd3);

    assign busy = (state == BURST);

    always_comb begin
        sel_data = data_in0_mux;
        case (sel)
            2'd0:    sel_data = data_in0_mux;
            2'd1:    sel_data = data_in1_mux;
            2'd2:    sel_data = data_in2_mux;
            default: sel_data = data_in3_mux;
        endcase
    end

    // In BURST, last always equals sel, so the picker naturally checks the
    // current lane last: an exhausted lane yields to any other requester but
    // is re-granted when it is the only one left.
    rr_pick4 u_pick (
        .req   (req),
        .last  (last),
        .hit   (pick_hit),
        .grant (pick)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= 2'd0;
            last      <= 2'd3;
            burst_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_hit) begin
                        state     <= BURST;
                        sel       <= pick;
                        last      <= pick;
                        burst_cnt <= 4'd0;
                    end
                end
                default: begin
                    // Backpressure freezes the whole burst.
                    if (slot_free) begin
                        if (acc && (burst_cnt != BURST_LAST)) begin
                            burst_cnt <= burst_cnt + 4'd1;
                        end else if (pick_hit) begin
                            // Burst exhausted or lane drained: re-grant with no bubble.
                            sel       <= pick;
                            last      <= pick;
                            burst_cnt <= 4'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            validout    <= 1'b0;
            dataout_mux <= '0;
        end else if (acc) begin
            validout    <= 1'b1;
            dataout_mux <= sel_data;
        end else if (slot_free) begin
            validout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux4_lane_scheduler.sv
// Self-checking bench for mux4_lane_scheduler: directed scenarios followed by
// a randomized phase, all compared cycle by cycle against a behavioural model
// that tracks "granted lane / bytes taken this grant" and byte queues.
module tb_mux4_lane_scheduler;

    localparam int MAX_BURST = 4;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic       valid0, valid1, valid2, valid3;
    logic [7:0] data_in0_mux, data_in1_mux, data_in2_mux, data_in3_mux;
    logic       pop0, pop1, pop2, pop3;
    logic       out_ready;
    logic       validout;
    logic [7:0] dataout_mux;
    logic [1:0] sel;
    logic       busy;

    always #5 clk_4f = ~clk_4f;

    mux4_lane_scheduler #(.DATA_W(8), .MAX_BURST(MAX_BURST)) dut (
        .clk_4f       (clk_4f),
        .reset        (reset),
        .valid0       (valid0),
        .valid1       (valid1),
        .valid2       (valid2),
        .valid3       (valid3),
        .data_in0_mux (data_in0_mux),
        .data_in1_mux (data_in1_mux),
        .data_in2_mux (data_in2_mux),
        .data_in3_mux (data_in3_mux),
        .pop0         (pop0),
        .pop1         (pop1),
        .pop2         (pop2),
        .pop3         (pop3),
        .out_ready    (out_ready),
        .validout     (validout),
        .dataout_mux  (dataout_mux),
        .sel          (sel),
        .busy         (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Lane sources: a byte queue per lane plus an enable that gates valid.
    logic [7:0] lane_q [4][$];
    bit         lane_en [4];

    // Behavioural model state.
    bit         m_busy;
    int         m_lane;
    int         m_last;
    int         m_taken;
    bit         m_ov;
    logic [7:0] m_od;

    // Observation logs.
    logic [7:0] out_log [$];
    int         acc_lane [$];
    int         acc_tick [$];
    int         tick_no = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit lane_valid(input int i);
        return lane_en[i] && (lane_q[i].size() > 0);
    endfunction

    function automatic logic [7:0] lane_head(input int i);
        return (lane_q[i].size() > 0) ? lane_q[i][0] : 8'h00;
    endfunction

    // First requesting lane strictly after `after`, wrapping; `after` itself last.
    function automatic int rr_next(input bit [3:0] r, input int after);
        for (int k = 1; k <= 4; k++) begin
            if (r[(after + k) % 4]) return (after + k) % 4;
        end
        return -1;
    endfunction

    task automatic drive_lanes();
        valid0 = lane_valid(0); data_in0_mux = lane_head(0);
        valid1 = lane_valid(1); data_in1_mux = lane_head(1);
        valid2 = lane_valid(2); data_in2_mux = lane_head(2);
        valid3 = lane_valid(3); data_in3_mux = lane_head(3);
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_lane  = 0;
        m_last  = 3;
        m_taken = 0;
        m_ov    = 1'b0;
        m_od    = 8'h00;
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < 4; i++) begin
            lane_q[i].delete();
            lane_en[i] = 1'b0;
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model, return #1 after the rising edge.
    task automatic tick();
        bit [3:0]   req;
        bit         slot;
        bit         acc;
        logic [3:0] exp_pop;
        int         n;
        drive_lanes();
        @(negedge clk_4f);
        for (int i = 0; i < 4; i++) req[i] = lane_valid(i);
        slot    = !m_ov || out_ready;
        acc     = !reset && m_busy && req[m_lane] && slot;
        exp_pop = acc ? 4'(1 << m_lane) : 4'h0;

        check("pop",      32'({pop3, pop2, pop1, pop0}), 32'(exp_pop));
        check("validout", 32'(validout),    32'(m_ov));
        check("dataout",  32'(dataout_mux), 32'(m_od));
        check("sel",      32'(sel),         32'(m_lane));
        check("busy",     32'(busy),        32'(m_busy));

        if (validout === 1'b1 && out_ready === 1'b1) out_log.push_back(dataout_mux);
        if (pop0 === 1'b1) begin acc_lane.push_back(0); acc_tick.push_back(tick_no); end
        if (pop1 === 1'b1) begin acc_lane.push_back(1); acc_tick.push_back(tick_no); end
        if (pop2 === 1'b1) begin acc_lane.push_back(2); acc_tick.push_back(tick_no); end
        if (pop3 === 1'b1) begin acc_lane.push_back(3); acc_tick.push_back(tick_no); end

        if (reset) begin
            model_reset();
        end else begin
            if (acc) begin
                m_od = lane_q[m_lane].pop_front();
                m_ov = 1'b1;
            end else if (slot) begin
                m_ov = 1'b0;
            end
            if (!m_busy) begin
                n = rr_next(req, m_last);
                if (n >= 0) begin
                    m_busy = 1'b1; m_lane = n; m_last = n; m_taken = 0;
                end
            end else if (slot) begin
                if (acc && (m_taken + 1 < MAX_BURST)) begin
                    m_taken++;
                end else begin
                    n = rr_next(req, m_lane);
                    if (n >= 0) begin
                        m_lane = n; m_last = n; m_taken = 0;
                    end else begin
                        m_busy = 1'b0;
                    end
                end
            end
        end
        tick_no++;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic do_reset();
        clear_lanes();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_log.delete();
        acc_lane.delete();
        acc_tick.delete();
    endtask

    initial begin
        // 1: reset held with every lane valid.
        reset     = 1'b1;
        out_ready = 1'b1;
        clear_lanes();
        for (int i = 0; i < 4; i++) begin
            lane_en[i] = 1'b1;
            for (int k = 0; k < 4; k++) lane_q[i].push_back(8'((i << 4) | k));
        end
        drive_lanes();
        model_reset();
        @(posedge clk_4f);
        #1;
        repeat (3) tick();
        check("t1_no_pops", 32'(acc_lane.size()), 32'd0);

        // 2: lane2 alone, six bytes, second burst follows without a gap.
        do_reset();
        lane_en[2] = 1'b1;
        for (int k = 0; k < 6; k++) lane_q[2].push_back(8'(8'hA0 + k));
        repeat (9) tick();
        check("t2_count", 32'(out_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < out_log.size(); k++)
            check("t2_byte", 32'(out_log[k]), 32'(8'hA0 + k));
        if (acc_tick.size() == 6) check("t2_no_gap", 32'(acc_tick[5] - acc_tick[0]), 32'd5);
        else check("t2_accepts", 32'(acc_tick.size()), 32'd6);

        // 3: all lanes streaming: 0,1,2,3,0 with four bytes each.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            lane_en[i] = 1'b1;
            for (int k = 0; k < 24; k++) lane_q[i].push_back(8'((i << 5) | k));
        end
        repeat (21) tick();
        check("t3_accepts", 32'(acc_lane.size()), 32'd20);
        for (int j = 0; j < 20 && j < acc_lane.size(); j++)
            check("t3_lane", 32'(acc_lane[j]), 32'((j / 4) % 4));
        if (acc_tick.size() == 20) check("t3_no_idle", 32'(acc_tick[19] - acc_tick[0]), 32'd19);

        // 4: lane1 stalled by out_ready=0 for three cycles mid-burst.
        do_reset();
        lane_en[1] = 1'b1;
        for (int k = 0; k < 10; k++) lane_q[1].push_back(8'(8'h10 + k));
        repeat (3) tick();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("t4_hold_valid", 32'(validout), 32'd1);
            check("t4_hold_data",  32'(dataout_mux), 32'h11);
            check("t4_no_pop",     32'(pop1), 32'd0);
        end
        out_ready = 1'b1;
        repeat (14) tick();
        check("t4_count", 32'(out_log.size()), 32'd10);
        for (int k = 0; k < 10 && k < out_log.size(); k++)
            check("t4_byte", 32'(out_log[k]), 32'(8'h10 + k));

        // 5: lane3 drains after two bytes while lane0 waits.
        do_reset();
        lane_en[3] = 1'b1;
        lane_q[3].push_back(8'h30);
        lane_q[3].push_back(8'h31);
        tick();
        lane_en[0] = 1'b1;
        for (int k = 0; k < 6; k++) lane_q[0].push_back(8'(8'h00 + k));
        repeat (10) tick();
        check("t5_accepts", 32'(acc_lane.size()), 32'd8);
        for (int j = 0; j < 6 && j < acc_lane.size(); j++)
            check("t5_lane", 32'(acc_lane[j]), (j < 2) ? 32'd3 : 32'd0);
        if (acc_tick.size() >= 3) check("t5_regrant", 32'(acc_tick[2] - acc_tick[1]), 32'd2);

        // 6: reset mid-burst, then lowest-index valid lane wins.
        do_reset();
        lane_en[2] = 1'b1;
        for (int k = 0; k < 8; k++) lane_q[2].push_back(8'(8'h20 + k));
        repeat (3) tick();
        check("t6_pre_valid", 32'(validout), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_validout", 32'(validout), 32'd0);
        check("t6_busy",     32'(busy), 32'd0);
        lane_en[2] = 1'b0;
        lane_en[1] = 1'b1;
        lane_en[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lane_q[1].push_back(8'(8'h40 + k));
            lane_q[3].push_back(8'(8'h60 + k));
        end
        tick();
        check("t6_grant_sel",  32'(sel), 32'd1);
        check("t6_grant_busy", 32'(busy), 32'd1);

        // Randomized traffic, backpressure and occasional reset.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) lane_en[i] = !lane_en[i];
                if (lane_q[i].size() < 3 && $urandom_range(0, 1) == 1)
                    lane_q[i].push_back(8'($urandom_range(0, 255)));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            reset     = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
